// File: rtl/galivan_pkg.sv
// Shared widths, FSM encodings, region selects and default ROM map for the ioctl ROM loader.
package galivan_pkg;

    localparam int unsigned ADDR_W      = 27;
    localparam int unsigned BYTE_ADDR_W = 24;
    localparam int unsigned OFF_W       = 18;
    localparam int unsigned SEL_W       = 4;
    localparam int unsigned INDEX_W     = 8;
    localparam int unsigned WORD_W      = 16;
    localparam int unsigned BYTE_W      = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WR_LO = 2'd1;
    localparam logic [1:0] WR_HI = 2'd2;

    localparam logic [SEL_W-1:0] SEL_NONE = 4'b0000;
    localparam logic [SEL_W-1:0] SEL_MAIN = 4'b0001;
    localparam logic [SEL_W-1:0] SEL_SND  = 4'b0010;
    localparam logic [SEL_W-1:0] SEL_TILE = 4'b0100;
    localparam logic [SEL_W-1:0] SEL_SPR  = 4'b1000;

    localparam logic [BYTE_ADDR_W-1:0] DEF_R1_BASE    = 24'h014000;
    localparam logic [BYTE_ADDR_W-1:0] DEF_R2_BASE    = 24'h018000;
    localparam logic [BYTE_ADDR_W-1:0] DEF_R3_BASE    = 24'h028000;
    localparam logic [BYTE_ADDR_W-1:0] DEF_ROM_END    = 24'h038000;
    localparam logic [INDEX_W-1:0]     DEF_LOAD_INDEX = 8'd0;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [OFF_W-1:0] offset;
        logic             in_range;
    } region_t;

endpackage

// File: rtl/rom_loader_if.sv
// ioctl download stream from hps_io plus the byte-wide ROM write port and status flags.
interface rom_loader_if;
    import galivan_pkg::*;

    logic                ioctl_download;
    logic [INDEX_W-1:0]  ioctl_index;
    logic                ioctl_wr;
    logic [ADDR_W-1:0]   ioctl_addr;
    logic [WORD_W-1:0]   ioctl_dout;
    logic                ioctl_wait;
    logic                rom_we;
    logic [SEL_W-1:0]    rom_sel;
    logic [OFF_W-1:0]    rom_addr;
    logic [BYTE_W-1:0]   rom_data;
    logic                load_done;
    logic                overrun;
    logic                range_err;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  ioctl_wait, rom_we, rom_sel, rom_addr, rom_data, load_done, overrun, range_err
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output ioctl_wait, rom_we, rom_sel, rom_addr, rom_data, load_done, overrun, range_err
    );

endinterface

// File: rtl/rom_region_dec.sv
// Combinational byte-address decoder: one-hot ROM region, offset within it, and in-range flag.
module rom_region_dec
    import galivan_pkg::*;
#(
    parameter logic [BYTE_ADDR_W-1:0] R1_BASE = DEF_R1_BASE,
    parameter logic [BYTE_ADDR_W-1:0] R2_BASE = DEF_R2_BASE,
    parameter logic [BYTE_ADDR_W-1:0] R3_BASE = DEF_R3_BASE,
    parameter logic [BYTE_ADDR_W-1:0] ROM_END = DEF_ROM_END
) (
    input  logic [ADDR_W-1:0] addr,
    output region_t           region
);

    logic [BYTE_ADDR_W-1:0] a;
    logic                   high_zero;

    assign a         = addr[BYTE_ADDR_W-1:0];
    assign high_zero = (addr[ADDR_W-1:BYTE_ADDR_W] == '0);

    always_comb begin
        region = '0;
        if (high_zero) begin
            if (a < R1_BASE)
                region = '{sel: SEL_MAIN, offset: OFF_W'(a), in_range: 1'b1};
            else if (a < R2_BASE)
                region = '{sel: SEL_SND, offset: OFF_W'(a - R1_BASE), in_range: 1'b1};
            else if (a < R3_BASE)
                region = '{sel: SEL_TILE, offset: OFF_W'(a - R2_BASE), in_range: 1'b1};
            else if (a < ROM_END)
                region = '{sel: SEL_SPR, offset: OFF_W'(a - R3_BASE), in_range: 1'b1};
        end
    end

endmodule

// File: rtl/rom_loader.sv
// Turns 16-bit ioctl download words into two byte writes (low byte first) on the region-decoded ROM port.
module rom_loader
    import galivan_pkg::*;
#(
    parameter logic [BYTE_ADDR_W-1:0] R1_BASE    = DEF_R1_BASE,
    parameter logic [BYTE_ADDR_W-1:0] R2_BASE    = DEF_R2_BASE,
    parameter logic [BYTE_ADDR_W-1:0] R3_BASE    = DEF_R3_BASE,
    parameter logic [BYTE_ADDR_W-1:0] ROM_END    = DEF_ROM_END,
    parameter logic [INDEX_W-1:0]     LOAD_INDEX = DEF_LOAD_INDEX
) (
    input  logic         clk_sys,
    input  logic         reset,
    rom_loader_if.slave  bus
);

    logic [1:0]        state, state_nx;
    logic [ADDR_W-1:0] lat_addr, lat_addr_nx;
    logic [BYTE_W-1:0] lat_hi, lat_hi_nx;
    logic              we_q, we_nx, wait_q, wait_nx;
    logic [SEL_W-1:0]  sel_q, sel_nx;
    logic [OFF_W-1:0]  addr_q, addr_nx;
    logic [BYTE_W-1:0] data_q, data_nx;
    logic              done_q, done_nx, ovr_q, ovr_nx, rerr_q, rerr_nx;
    logic              dl_q, dl_ok_q, dl_ok_nx, pend_q, pend_nx;

    logic              accept, rise, fall, phase;
    logic [ADDR_W-1:0] dec_addr;
    logic [BYTE_W-1:0] dec_byte;
    region_t           region;

    assign accept = bus.ioctl_wr & bus.ioctl_download & (bus.ioctl_index == LOAD_INDEX);
    assign rise   = bus.ioctl_download & ~dl_q;
    assign fall   = ~bus.ioctl_download & dl_q;

    // The decoder looks one byte ahead so the registered write port lines up with WR_LO/WR_HI.
    assign dec_addr = (state == IDLE) ? (bus.ioctl_addr & ~ADDR_W'(1)) : (lat_addr | ADDR_W'(1));
    assign dec_byte = (state == IDLE) ? bus.ioctl_dout[BYTE_W-1:0] : lat_hi;

    rom_region_dec #(
        .R1_BASE (R1_BASE),
        .R2_BASE (R2_BASE),
        .R3_BASE (R3_BASE),
        .ROM_END (ROM_END)
    ) u_dec (
        .addr   (dec_addr),
        .region (region)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= IDLE;
            lat_addr <= '0;
            lat_hi   <= '0;
            we_q     <= 1'b0;
            wait_q   <= 1'b0;
            sel_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            rerr_q   <= 1'b0;
            dl_q     <= 1'b0;
            dl_ok_q  <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            lat_addr <= lat_addr_nx;
            lat_hi   <= lat_hi_nx;
            we_q     <= we_nx;
            wait_q   <= wait_nx;
            sel_q    <= sel_nx;
            addr_q   <= addr_nx;
            data_q   <= data_nx;
            done_q   <= done_nx;
            ovr_q    <= ovr_nx;
            rerr_q   <= rerr_nx;
            dl_q     <= bus.ioctl_download;
            dl_ok_q  <= dl_ok_nx;
            pend_q   <= pend_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        lat_addr_nx = lat_addr;
        lat_hi_nx   = lat_hi;
        phase       = 1'b0;
        we_nx       = 1'b0;
        wait_nx     = 1'b0;
        sel_nx      = sel_q;
        addr_nx     = addr_q;
        data_nx     = data_q;
        done_nx     = rise ? 1'b0 : done_q;
        ovr_nx      = rise ? 1'b0 : ovr_q;
        rerr_nx     = rise ? 1'b0 : rerr_q;
        dl_ok_nx    = rise ? (bus.ioctl_index == LOAD_INDEX) : dl_ok_q;
        pend_nx     = rise ? 1'b0 : pend_q;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx    = WR_LO;
                    lat_addr_nx = bus.ioctl_addr;
                    lat_hi_nx   = bus.ioctl_dout[WORD_W-1:BYTE_W];
                    phase       = 1'b1;
                end
            end
            WR_LO: begin
                state_nx = WR_HI;
                phase    = 1'b1;
            end
            WR_HI:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        if (accept && (state != IDLE))
            ovr_nx = 1'b1;

        // Out-of-range bytes clear the select but leave address/data holding their last write.
        if (phase) begin
            wait_nx = 1'b1;
            sel_nx  = region.sel;
            if (region.in_range) begin
                we_nx   = 1'b1;
                addr_nx = region.offset;
                data_nx = dec_byte;
            end else begin
                rerr_nx = 1'b1;
            end
        end

        // A download that ends mid-word reports done only once the loader is back in IDLE.
        if (!rise && ((fall && dl_ok_q) || pend_q)) begin
            if (state_nx == IDLE) begin
                done_nx = 1'b1;
                pend_nx = 1'b0;
            end else begin
                pend_nx = 1'b1;
            end
        end
    end

    assign bus.ioctl_wait = wait_q;
    assign bus.rom_we     = we_q;
    assign bus.rom_sel    = sel_q;
    assign bus.rom_addr   = addr_q;
    assign bus.rom_data   = data_q;
    assign bus.load_done  = done_q;
    assign bus.overrun    = ovr_q;
    assign bus.range_err  = rerr_q;

endmodule

// File: tb/tb_rom_loader.sv
// Directed self-checking bench for rom_loader: byte serialisation, region decode, flags and reset abort.
module tb_rom_loader;
    import galivan_pkg::*;

    logic clk_sys = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    int   we_cnt   = 0;
    int   base;

    rom_loader_if bus();

    rom_loader dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) if (bus.rom_we === 1'b1) we_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic strobe(input logic [26:0] a, input logic [15:0] d);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        step();
        bus.ioctl_wr   = 1'b0;
    endtask

    task automatic check_wr(input string tag, input logic [3:0] sel, input logic [17:0] a, input logic [7:0] d);
        check({tag, "_we"},   32'(bus.rom_we),   32'd1);
        check({tag, "_sel"},  32'(bus.rom_sel),  32'(sel));
        check({tag, "_addr"}, 32'(bus.rom_addr), 32'(a));
        check({tag, "_data"}, 32'(bus.rom_data), 32'(d));
    endtask

    task automatic start_dl(input logic [7:0] idx);
        bus.ioctl_download = 1'b1;
        bus.ioctl_index    = idx;
        step();
    endtask

    initial begin
        reset              = 1'b1;
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        step();
        step();
        check("rst_we",    32'(bus.rom_we),     32'd0);
        check("rst_wait",  32'(bus.ioctl_wait), 32'd0);
        check("rst_sel",   32'(bus.rom_sel),    32'd0);
        check("rst_addr",  32'(bus.rom_addr),   32'd0);
        check("rst_data",  32'(bus.rom_data),   32'd0);
        check("rst_done",  32'(bus.load_done),  32'd0);
        check("rst_ovr",   32'(bus.overrun),    32'd0);
        check("rst_rerr",  32'(bus.range_err),  32'd0);
        reset = 1'b0;
        step();

        // Basic word: low byte then high byte, wait high for exactly two cycles
        start_dl(8'd0);
        check("t1_wait_pre", 32'(bus.ioctl_wait), 32'd0);
        strobe(27'h000010, 16'hBEEF);
        check_wr("t1_lo", 4'b0001, 18'h00010, 8'hEF);
        check("t1_wait_lo", 32'(bus.ioctl_wait), 32'd1);
        step();
        check_wr("t1_hi", 4'b0001, 18'h00011, 8'hBE);
        check("t1_wait_hi", 32'(bus.ioctl_wait), 32'd1);
        step();
        check("t1_we_idle",   32'(bus.rom_we),     32'd0);
        check("t1_wait_idle", 32'(bus.ioctl_wait), 32'd0);
        check("t1_addr_hold", 32'(bus.rom_addr),   32'h11);

        // Region 0 -> region 1 boundary
        strobe(27'h013FFE, 16'h1234);
        check_wr("t2_r0_lo", 4'b0001, 18'h13FFE, 8'h34);
        step();
        check_wr("t2_r0_hi", 4'b0001, 18'h13FFF, 8'h12);
        step();
        strobe(27'h014000, 16'h5678);
        check_wr("t2_r1_lo", 4'b0010, 18'h00000, 8'h78);
        step();
        check_wr("t2_r1_hi", 4'b0010, 18'h00001, 8'h56);
        step();

        // Region 2 start, then last sprite word and first out-of-range word
        strobe(27'h018000, 16'h0102);
        check_wr("t3_r2_lo", 4'b0100, 18'h00000, 8'h02);
        step();
        step();
        strobe(27'h037FFE, 16'hAA55);
        check_wr("t3_r3_lo", 4'b1000, 18'h0FFFE, 8'h55);
        step();
        check_wr("t3_r3_hi", 4'b1000, 18'h0FFFF, 8'hAA);
        check("t3_rerr_before", 32'(bus.range_err), 32'd0);
        step();
        base = we_cnt;
        strobe(27'h038000, 16'h1111);
        check("t3_oor_we",   32'(bus.rom_we),    32'd0);
        check("t3_oor_sel",  32'(bus.rom_sel),   32'd0);
        check("t3_oor_rerr", 32'(bus.range_err), 32'd1);
        step();
        check("t3_oor_we_hi", 32'(bus.rom_we), 32'd0);
        step();
        check("t3_oor_cnt", 32'(we_cnt - base), 32'd0);
        strobe(27'h1000010, 16'h2222);
        check("t3_hibits_we", 32'(bus.rom_we), 32'd0);
        step();
        step();

        // Overrun: second accepted strobe one cycle after the first is dropped
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 27'h000100;
        bus.ioctl_dout = 16'hCAFE;
        step();
        bus.ioctl_addr = 27'h000200;
        bus.ioctl_dout = 16'hDEAD;
        check_wr("t4_lo", 4'b0001, 18'h00100, 8'hFE);
        check("t4_ovr_pre", 32'(bus.overrun), 32'd0);
        step();
        bus.ioctl_wr = 1'b0;
        check_wr("t4_hi", 4'b0001, 18'h00101, 8'hCA);
        check("t4_ovr", 32'(bus.overrun), 32'd1);
        step();
        check("t4_we_idle", 32'(bus.rom_we), 32'd0);
        strobe(27'h000300, 16'h4321);
        check_wr("t4_next_lo", 4'b0001, 18'h00300, 8'h21);
        step();
        check_wr("t4_next_hi", 4'b0001, 18'h00301, 8'h43);
        step();
        bus.ioctl_download = 1'b0;
        step();
        check("t4_done", 32'(bus.load_done), 32'd1);

        // Index 1 download: strobes ignored, no done; rise clears sticky flags
        start_dl(8'd1);
        check("t5_done_clr", 32'(bus.load_done), 32'd0);
        check("t5_ovr_clr",  32'(bus.overrun),   32'd0);
        check("t5_rerr_clr", 32'(bus.range_err), 32'd0);
        base = we_cnt;
        for (int i = 0; i < 2; i++) begin
            strobe(27'(32'h40 + 2 * i), 16'h7777);
            step();
            step();
        end
        bus.ioctl_download = 1'b0;
        step();
        step();
        check("t5_cnt",  32'(we_cnt - base), 32'd0);
        check("t5_done", 32'(bus.load_done), 32'd0);

        // Index 0 download of 4 words
        start_dl(8'd0);
        base = we_cnt;
        for (int i = 0; i < 4; i++) begin
            strobe(27'(32'h400 + 2 * i), 16'(32'hA0B0 + i));
            check("t6_wait", 32'(bus.ioctl_wait), 32'd1);
            step();
            step();
        end
        bus.ioctl_download = 1'b0;
        step();
        check("t6_cnt",  32'(we_cnt - base), 32'd8);
        check("t6_done", 32'(bus.load_done), 32'd1);
        step();
        step();
        check("t6_done_hold", 32'(bus.load_done), 32'd1);
        start_dl(8'd5);
        check("t6_done_rise", 32'(bus.load_done), 32'd0);
        bus.ioctl_download = 1'b0;
        step();
        check("t6_done_idx5", 32'(bus.load_done), 32'd0);

        // Download drops while busy: word completes, done follows the WR_HI cycle
        start_dl(8'd0);
        strobe(27'h000500, 16'h6655);
        bus.ioctl_download = 1'b0;
        check_wr("t7_lo", 4'b0001, 18'h00500, 8'h55);
        step();
        check_wr("t7_hi", 4'b0001, 18'h00501, 8'h66);
        check("t7_done_busy", 32'(bus.load_done), 32'd0);
        step();
        check("t7_done", 32'(bus.load_done), 32'd1);

        // Reset in WR_LO aborts the word; later strobes of the download still work
        start_dl(8'd0);
        strobe(27'h000600, 16'h3344);
        check("t8_we_lo", 32'(bus.rom_we), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t8_we",   32'(bus.rom_we),     32'd0);
        check("t8_wait", 32'(bus.ioctl_wait), 32'd0);
        check("t8_done", 32'(bus.load_done),  32'd0);
        check("t8_ovr",  32'(bus.overrun),    32'd0);
        check("t8_rerr", 32'(bus.range_err),  32'd0);
        step();
        strobe(27'h000020, 16'h9A8B);
        check_wr("t8_lo", 4'b0001, 18'h00020, 8'h8B);
        step();
        check_wr("t8_hi", 4'b0001, 18'h00021, 8'h9A);
        step();
        check("t8_idle", 32'(bus.rom_we), 32'd0);
        bus.ioctl_download = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
